// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes and FSM states for the calculator entry path.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_AND = 3'd2,
    OP_SUB = 3'd3,
    OP_OR  = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    WAIT_ALU = 2'd2,
    SHOW_RES = 2'd3
  } calc_state_e;

  function automatic logic is_op_key(input logic [4:0] v);
    return (v == KEY_ADD) || (v == KEY_MUL) || (v == KEY_AND) ||
           (v == KEY_SUB) || (v == KEY_OR);
  endfunction

  function automatic alu_op_e key_to_op(input logic [4:0] v);
    case (v)
      KEY_MUL: return OP_MUL;
      KEY_AND: return OP_AND;
      KEY_SUB: return OP_SUB;
      KEY_OR:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_digit_shift_reg.sv
// Operand register: shifts in one nibble per digit, saturating digit count, clear and parallel load.
// Clear plus shift in one cycle yields a single-digit value with count 1.
module digit_shift_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic [3:0]   digit_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] val_o,
  output logic [W-1:0] val_nxt_o
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [W-1:0]  val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      val_d = '0;
      cnt_d = '0;
    end
    // A loaded value counts as a full operand so later digits cannot extend it.
    if (load_i) begin
      val_d = load_val_i;
      cnt_d = CW'(DIGITS);
    end else if (shift_i && (cnt_d != CW'(DIGITS))) begin
      val_d = W'({val_d, digit_i});
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o     = val_q;
  assign val_nxt_o = val_d;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator keypad sequencer: operand entry, ALU req/ack with timeout, registered display.
// Optional BCD entry restriction enabled by defining CALC_DEC_MODE_EN.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 255,
  localparam int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [4:0]   val,
  input  logic         mode_dec,
  output logic         restriction,
  output logic         alu_req,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic         alu_ack,
  input  logic [W-1:0] alu_res,
  output logic [W-1:0] disp_val,
  output logic [1:0]   disp_sel,
  output logic         err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  calc_state_e   state_q, state_d;
  alu_op_e       op_q, op_d;
  logic [W-1:0]  r_q, r_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          req_q, restr_q, restr_d;
  logic [W-1:0]  disp_val_q, disp_val_d;
  logic [1:0]    disp_sel_q, disp_sel_d;
  logic          a_clr, a_shift, a_load, b_clr, b_shift, acc;
  logic [W-1:0]  a_nxt, b_nxt;
  logic          dig_ok, is_dig, is_op, is_exe, is_ce, is_clr;

`ifdef CALC_DEC_MODE_EN
  assign dig_ok  = !(mode_dec && (val[3:0] > 4'h9));
  assign restr_d = mode_dec;
`else
  logic unused_mode_dec;
  assign unused_mode_dec = mode_dec;
  assign dig_ok  = 1'b1;
  assign restr_d = 1'b0;
`endif

  assign is_dig = sel && !val[4] && dig_ok;
  assign is_op  = sel && is_op_key(val);
  assign is_exe = sel && (val == KEY_EXE);
  assign is_ce  = sel && (val == KEY_CE);
  assign is_clr = sel && (val == KEY_CLR);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    a_clr   = 1'b0;
    a_shift = 1'b0;
    a_load  = 1'b0;
    b_clr   = 1'b0;
    b_shift = 1'b0;
    acc     = 1'b0;
    case (state_q)
      ENTER_A: begin
        acc = is_dig || is_op || is_ce || is_clr;
        if (is_dig) a_shift = 1'b1;
        else if (is_op) begin
          op_d    = key_to_op(val);
          b_clr   = 1'b1;
          state_d = ENTER_B;
        end else if (is_ce) a_clr = 1'b1;
        else if (is_clr) begin
          a_clr = 1'b1;
          b_clr = 1'b1;
          r_d   = '0;
          op_d  = OP_ADD;
        end
      end
      ENTER_B: begin
        acc = is_dig || is_op || is_exe || is_ce || is_clr;
        if (is_dig) b_shift = 1'b1;
        else if (is_op) op_d = key_to_op(val);
        else if (is_exe) begin
          tmo_d   = '0;
          state_d = WAIT_ALU;
        end else if (is_ce) b_clr = 1'b1;
        else if (is_clr) begin
          a_clr   = 1'b1;
          b_clr   = 1'b1;
          r_d     = '0;
          op_d    = OP_ADD;
          state_d = ENTER_A;
        end
      end
      WAIT_ALU: begin
        if (alu_ack) begin
          r_d     = alu_res;
          state_d = SHOW_RES;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          r_d     = '0;
          err_d   = 1'b1;
          state_d = SHOW_RES;
        end else tmo_d = tmo_q + 1'b1;
      end
      default: begin
        acc = is_dig || is_op || is_exe || is_ce || is_clr;
        if (is_dig) begin
          a_clr   = 1'b1;
          a_shift = 1'b1;
          state_d = ENTER_A;
        end else if (is_op) begin
          a_load  = 1'b1;
          op_d    = key_to_op(val);
          b_clr   = 1'b1;
          state_d = ENTER_B;
        end else if (is_exe) begin
          a_load  = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_ALU;
        end else if (is_ce || is_clr) begin
          a_clr   = 1'b1;
          b_clr   = 1'b1;
          r_d     = '0;
          op_d    = OP_ADD;
          state_d = ENTER_A;
        end
      end
    endcase
    if (acc) err_d = 1'b0;
  end

  digit_shift_reg #(.DIGITS(DIGITS), .W(W)) u_reg_a (
    .clk(clk), .rst(rst), .clr_i(a_clr), .shift_i(a_shift), .digit_i(val[3:0]),
    .load_i(a_load), .load_val_i(r_q), .val_o(alu_a), .val_nxt_o(a_nxt)
  );

  digit_shift_reg #(.DIGITS(DIGITS), .W(W)) u_reg_b (
    .clk(clk), .rst(rst), .clr_i(b_clr), .shift_i(b_shift), .digit_i(val[3:0]),
    .load_i(1'b0), .load_val_i('0), .val_o(alu_b), .val_nxt_o(b_nxt)
  );

  // Display follows the next state so the shown value is a register, not a mux of registers.
  always_comb begin
    disp_val_d = a_nxt;
    disp_sel_d = 2'd0;
    case (state_d)
      ENTER_B, WAIT_ALU: begin
        disp_val_d = b_nxt;
        disp_sel_d = 2'd1;
      end
      SHOW_RES: begin
        disp_val_d = r_d;
        disp_sel_d = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTER_A;
      op_q       <= OP_ADD;
      r_q        <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      restr_q    <= 1'b0;
      disp_val_q <= '0;
      disp_sel_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      r_q        <= r_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      req_q      <= (state_d == WAIT_ALU);
      restr_q    <= restr_d;
      disp_val_q <= disp_val_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  assign alu_req     = req_q;
  assign alu_op      = op_q;
  assign err         = err_q;
  assign restriction = restr_q;
  assign disp_val    = disp_val_q;
  assign disp_sel    = disp_sel_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: directed key sequences, ALU handshake, timeout and reset.
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  localparam int DIGITS = 4;
  localparam int TMO    = 255;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0, rst = 1'b1, sel = 1'b0, mode_dec = 1'b0, alu_ack = 1'b0;
  logic [4:0]   val = 5'd0;
  logic [W-1:0] alu_res = '0;
  logic         restriction, alu_req, err;
  logic [W-1:0] alu_a, alu_b, disp_val;
  logic [2:0]   alu_op;
  logic [1:0]   disp_sel;

  always #5 clk = ~clk;

  calc_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .val(val), .mode_dec(mode_dec),
    .restriction(restriction), .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_ack(alu_ack), .alu_res(alu_res),
    .disp_val(disp_val), .disp_sel(disp_sel), .err(err)
  );

  typedef struct packed {
    logic [W-1:0] dv;
    logic [1:0]   ds;
    logic         er;
    logic         rq;
    logic         rs;
  } disp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } alu_t;

  disp_t dq[$];
  string dn[$];
  alu_t  aq[$];
  int    n_chk = 0, n_fail = 0;
  logic  prb = 1'b0, trig_q = 1'b0, req_prev_q = 1'b0;
  disp_t d_exp, d_got;
  alu_t  a_exp, a_got;
  string d_name;

  // Display monitor: one expected entry per sel pulse or probe, checked a cycle later.
  always @(posedge clk) trig_q <= sel | prb;

  always @(negedge clk) begin
    if (trig_q) begin
      d_got = {disp_val, disp_sel, err, alu_req, restriction};
      n_chk++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL disp_unexpected: got disp_val=%h sel=%0d, no expectation queued", disp_val, disp_sel);
      end else begin
        d_exp  = dq.pop_front();
        d_name = dn.pop_front();
        if (d_got !== d_exp) begin
          n_fail++;
          $display("FAIL %s: got disp_val=%h disp_sel=%0d err=%b alu_req=%b restriction=%b, expected disp_val=%h disp_sel=%0d err=%b alu_req=%b restriction=%b",
                   d_name, d_got.dv, d_got.ds, d_got.er, d_got.rq, d_got.rs,
                   d_exp.dv, d_exp.ds, d_exp.er, d_exp.rq, d_exp.rs);
        end
      end
    end
  end

  // ALU monitor: operands and opcode checked when a request is raised.
  always @(negedge clk) begin
    if (alu_req && !req_prev_q) begin
      a_got = {alu_a, alu_b, alu_op};
      n_chk++;
      if (aq.size() == 0) begin
        n_fail++;
        $display("FAIL alu_unexpected: got a=%h b=%h op=%0d, no request expected", alu_a, alu_b, alu_op);
      end else begin
        a_exp = aq.pop_front();
        if (a_got !== a_exp) begin
          n_fail++;
          $display("FAIL alu_req_operands: got a=%h b=%h op=%0d, expected a=%h b=%h op=%0d",
                   a_got.a, a_got.b, a_got.op, a_exp.a, a_exp.b, a_exp.op);
        end
      end
    end
    req_prev_q <= alu_req;
  end

  function automatic logic exp_restr();
`ifdef CALC_DEC_MODE_EN
    return mode_dec;
`else
    return 1'b0;
`endif
  endfunction

  // Caller is at a negedge; returns at the following negedge.
  task automatic stim(input logic s, input logic [4:0] v, input string nm,
                      input logic [W-1:0] dv, input logic [1:0] ds, input logic er, input logic rq);
    disp_t e;
    e.dv = dv; e.ds = ds; e.er = er; e.rq = rq; e.rs = exp_restr();
    dq.push_back(e);
    dn.push_back(nm);
    if (s) begin
      sel = 1'b1;
      val = v;
    end else prb = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    prb = 1'b0;
  endtask

  task automatic press(input logic [4:0] v, input string nm, input logic [W-1:0] dv,
                       input logic [1:0] ds, input logic er = 1'b0, input logic rq = 1'b0);
    stim(1'b1, v, nm, dv, ds, er, rq);
  endtask

  task automatic probe(input string nm, input logic [W-1:0] dv, input logic [1:0] ds,
                       input logic er, input logic rq);
    stim(1'b0, 5'd0, nm, dv, ds, er, rq);
  endtask

  task automatic exp_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    aq.push_back({a, b, op});
  endtask

  task automatic ack_after(input int n, input logic [W-1:0] res);
    repeat (n) @(negedge clk);
    n_chk++;
    if (alu_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_window: got alu_req=%b, expected 1", alu_req);
    end
    alu_ack = 1'b1;
    alu_res = res;
    @(negedge clk);
    alu_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    probe("reset", 16'h0, 2'd0, 1'b0, 1'b0);

    press(5'h1,    "a_1",      16'h0001, 2'd0);
    press(5'h2,    "a_12",     16'h0012, 2'd0);
    press(KEY_ADD, "add",      16'h0000, 2'd1);
    press(5'h3,    "b_3",      16'h0003, 2'd1);
    exp_alu(16'h0012, 16'h0003, 3'd0);
    press(KEY_EXE, "exe1",     16'h0003, 2'd1, 1'b0, 1'b1);
    press(KEY_CLR, "wait_clr", 16'h0003, 2'd1, 1'b0, 1'b1);
    ack_after(2, 16'h0015);
    probe("res1", 16'h0015, 2'd2, 1'b0, 1'b0);

    exp_alu(16'h0015, 16'h0003, 3'd0);
    press(KEY_EXE, "exe_repeat", 16'h0003, 2'd1, 1'b0, 1'b1);
    ack_after(0, 16'h0018);
    probe("res2", 16'h0018, 2'd2, 1'b0, 1'b0);

    press(KEY_MUL, "mul_from_res", 16'h0000, 2'd1);
    press(5'h2,    "b_2",          16'h0002, 2'd1);
    press(KEY_SUB, "op_replace",   16'h0002, 2'd1);
    exp_alu(16'h0018, 16'h0002, 3'd3);
    press(KEY_EXE, "exe3",         16'h0002, 2'd1, 1'b0, 1'b1);
    ack_after(0, 16'h0016);
    probe("res3", 16'h0016, 2'd2, 1'b0, 1'b0);

    press(5'h1,    "new_a_1",  16'h0001, 2'd0);
    press(5'h2,    "a_12b",    16'h0012, 2'd0);
    press(5'h3,    "a_123",    16'h0123, 2'd0);
    press(5'h4,    "a_1234",   16'h1234, 2'd0);
    press(5'h5,    "a_sat",    16'h1234, 2'd0);
    press(KEY_EXE, "exe_in_a", 16'h1234, 2'd0);
    press(KEY_CE,  "ce_a",     16'h0000, 2'd0);
    press(5'h19,   "invalid",  16'h0000, 2'd0);
    press(5'hA,    "hex_a",    16'h000A, 2'd0);
    press(KEY_CLR, "clr_a",    16'h0000, 2'd0);

    press(5'h5,    "a_5",      16'h0005, 2'd0);
    press(KEY_AND, "and",      16'h0000, 2'd1);
    press(5'h6,    "b_6",      16'h0006, 2'd1);
    press(KEY_CE,  "ce_b",     16'h0000, 2'd1);
    press(5'h7,    "b_7",      16'h0007, 2'd1);
    press(KEY_CLR, "clr_b",    16'h0000, 2'd0);
    press(KEY_OR,  "or",       16'h0000, 2'd1);
    exp_alu(16'h0000, 16'h0000, 3'd4);
    press(KEY_EXE, "exe_tmo",  16'h0000, 2'd1, 1'b0, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    probe("pre_timeout", 16'h0000, 2'd1, 1'b0, 1'b1);
    probe("timeout",     16'h0000, 2'd2, 1'b1, 1'b0);
    press(5'h7, "err_clear", 16'h0007, 2'd0, 1'b0, 1'b0);

    press(KEY_ADD, "add2",     16'h0000, 2'd1);
    press(5'h2,    "b_2b",     16'h0002, 2'd1);
    exp_alu(16'h0007, 16'h0002, 3'd0);
    press(KEY_EXE, "exe4",     16'h0002, 2'd1, 1'b0, 1'b1);
    rst = 1'b1;
    probe("rst_in_wait", 16'h0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    alu_ack = 1'b1;
    alu_res = 16'hFFFF;
    @(negedge clk);
    alu_ack = 1'b0;
    probe("late_ack", 16'h0000, 2'd0, 1'b0, 1'b0);

`ifdef CALC_DEC_MODE_EN
    mode_dec = 1'b1;
    @(negedge clk);
    press(5'hA, "dec_hex_ignored", 16'h0000, 2'd0);
    press(5'h9, "dec_9",           16'h0009, 2'd0);
    mode_dec = 1'b0;
    @(negedge clk);
    probe("dec_off_keeps_a", 16'h0009, 2'd0, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    n_chk++;
    if (dq.size() != 0 || aq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d display and %0d alu expectations pending, expected 0", dq.size(), aq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-entry sequencer for the on-screen calculator. It consumes the cursor's selected code (`val`) on each `sel` pulse and builds two operands digit by digit. It latches the chosen operation, runs a request/acknowledge transaction with the ALU, and holds the result for display. It sits between the grid cursor and the ALU/VGA display path, and also drives the cursor's `restriction` input.

## Interface
Parameters:
- `DIGITS`, default 4: digits per operand (4 bits each); `W = 4*DIGITS`.
- `TIMEOUT`, default 255: maximum cycles to wait for `alu_ack`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sel`  in  1  one-cycle pulse: press at the current cursor position.
- `val`  in  5  cursor code: 0x00–0x0F digit; 0x10 add; 0x11 mul; 0x12 and; 0x13 EXE; 0x14 sub; 0x15 or; 0x16 CE; 0x17 CLR; 0x18–0x1F invalid.
- `mode_dec`  in  1  decimal mode request.
- `restriction`  out  1  to cursor: forbid hex-only keys.
- `alu_req`  out  1  operation request; held until acknowledged.
- `alu_a`, `alu_b`  out  W  operands; stable while `alu_req` is high.
- `alu_op`  out  3  operation: add=0, mul=1, and=2, sub=3, or=4.
- `alu_ack`  in  1  ALU done; `alu_res` is valid in the same cycle.
- `alu_res`  in  W  ALU result.
- `disp_val`  out  W  value to display.
- `disp_sel`  out  2  which value is shown: 0=A, 1=B, 2=result.
- `err`  out  1  ALU timeout flag.

## Operation
- A `sel` pulse is processed only in its own cycle. `val` is sampled with it. Invalid codes are ignored.
- Digit entry: `X <= {X[W-5:0], digit}` and `cnt++`. When `cnt == DIGITS`, further digits are ignored (saturate, no wrap).
- States and transitions:
  - **ENTER_A**
    - digit: shift into A.
    - op: latch op, clear B and its `cnt`, go to ENTER_B.
    - EXE: ignored.
    - CE: clear A and `cnt`.
    - CLR: clear all registers.
  - **ENTER_B**
    - digit: shift into B.
    - op: replace the latched op; B is kept.
    - EXE: go to WAIT_ALU.
    - CE: clear B and `cnt`.
    - CLR: clear all registers, go to ENTER_A.
  - **WAIT_ALU**
    - `alu_req=1`; every `sel` is ignored, including CLR.
    - `alu_ack`: R <= `alu_res`, go to SHOW_RES.
    - Timeout counter reaches `TIMEOUT` with no ack: R <= 0, `err <= 1`, go to SHOW_RES.
  - **SHOW_RES**
    - digit: A <= digit, `cnt = 1`, go to ENTER_A.
    - op: A <= R, latch op, clear B, go to ENTER_B.
    - EXE: A <= R, keep B and op, go to WAIT_ALU (repeat).
    - CE or CLR: clear all registers, go to ENTER_A.
- `err` clears on the next accepted `sel`.
- Display mapping:
  - ENTER_A: `disp_val` = A, `disp_sel` = 0.
  - ENTER_B and WAIT_ALU: `disp_val` = B, `disp_sel` = 1.
  - SHOW_RES: `disp_val` = R, `disp_sel` = 2.

## Timing
- All outputs are registered.
- Reset values: state ENTER_A; A, B, R, and `cnt` all 0; `alu_req=0`; `alu_op=0`; `disp_val=0`; `disp_sel=0`; `err=0`; `restriction=0`.
- A `sel` pulse in cycle n is reflected on the outputs in cycle n+1.
- `alu_req` rises in the cycle after EXE is accepted.
- `alu_req` falls in the cycle after `alu_ack`. `alu_ack` in the first request cycle is legal: the transaction is 1 cycle.
- Timeout: `err` rises `TIMEOUT+1` cycles after `alu_req` rises.
- `rst` during WAIT_ALU drops `alu_req` the next cycle. A late `alu_ack` is then ignored.

## Configuration
- Macro: `CALC_DEC_MODE_EN`.
- Defined:
  - `restriction` = registered `mode_dec`.
  - While `mode_dec=1`, digits 0xA–0xF are ignored (BCD entry).
  - Toggling `mode_dec` does not alter stored operands.
- Undefined: `mode_dec` is ignored, `restriction` is tied to 0, and all 16 digits are accepted.

## Structure
- Shared package `calc_pkg` holds:
  - the `val` code constants (`KEY_ADD`…`KEY_CLR`);
  - the `alu_op_e` enum;
  - the `calc_state_e` enum (ENTER_A, ENTER_B, WAIT_ALU, SHOW_RES).
- Sub-module `digit_shift_reg`, instantiated twice (A, B). It provides W-bit shift-in-nibble, saturating `cnt`, and clear.
- The FSM, timeout counter, and R register live in the top level.

## Test plan
- Reset → ENTER_A; `disp_val=0`, `disp_sel=0`, `alu_req=0`, `err=0`.
- Keys 1, 2, add, 3, EXE; ack 3 cycles later with `alu_res=0x0015` → `alu_a=0x0012`, `alu_b=0x0003`, `alu_op=0`. Afterwards `disp_val=0x0015`, `disp_sel=2`, `alu_req=0`.
- Keys 1, 2, 3, 4, 5 with DIGITS=4 → A=0x1234 (fifth digit ignored); CE → A=0.
- EXE with `alu_ack` held low → `err=1` at `TIMEOUT+1` cycles, `disp_val=0`; next digit 7 → `err=0`, A=0x0007.
- SHOW_RES with R=0x0015, then EXE with ack `alu_res=0x0018` → `alu_a=0x0015`, `alu_b=0x0003`, R=0x0018. CLR in ENTER_B → ENTER_A with A=B=0.
- With `CALC_DEC_MODE_EN` and `mode_dec=1`: key 0xA ignored, key 9 → A=0x0009, `restriction=1`.
